stream_framer: RTL and testbench

STREAM_FRAMER -- requirements
Module: stream_framer

---
 rtl/stream_framer_if.sv | 23 ++
 rtl/stream_framer.sv | 154 +++++++++++++++
 tb/tb_stream_framer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_framer_if.sv
// Handshake bundle between the multiplexer stage, the framer and the downstream sink.
// The framer side uses the slave modport; the driving/monitoring side uses master.
interface stream_framer_if;
  logic [15:0] multiplexed_data;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        frame_last;
  logic [7:0]  drop_count;

  modport master (
    output multiplexed_data, mode, in_valid, frame_ready,
    input  in_ready, frame_data, frame_valid, frame_last, drop_count
  );

  modport slave (
    input  multiplexed_data, mode, in_valid, frame_ready,
    output in_ready, frame_data, frame_valid, frame_last, drop_count
  );
endinterface

// File: rtl/stream_framer.sv
// Packs one channel of a tagged word stream into header + payload (+ checksum) frames.
// Define FRAMER_CKSUM_EN to append a 16-bit modulo-sum checksum word to every frame.
module stream_framer #(
  parameter int PAYLOAD_LEN = 4
) (
  input  logic           clk,
  input  logic           rst,
  stream_framer_if.slave bus
);

  // state   | meaning
  // IDLE    | waiting for a tagged word to open a frame; untagged words dropped
  // PAYLOAD | collecting PAYLOAD_LEN words of the latched channel
  // CKSUM   | emitting the checksum word (only with FRAMER_CKSUM_EN)
`ifdef FRAMER_CKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, CKSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, PAYLOAD} state_t;
`endif

  localparam logic [5:0] LAST_IDX = 6'(PAYLOAD_LEN - 1);

  state_t      r_state;
  logic [1:0]  r_ch;
  logic [5:0]  r_count;
  logic [15:0] r_data;
  logic        r_valid;
  logic        r_last;
  logic [7:0]  r_drop;
`ifdef FRAMER_CKSUM_EN
  logic [15:0] r_sum;
  logic [15:0] w_sum_nxt;
`endif

  state_t      w_state_nxt;
  logic [1:0]  w_ch_nxt;
  logic [5:0]  w_count_nxt;
  logic [15:0] w_data_nxt;
  logic        w_valid_nxt;
  logic        w_last_nxt;
  logic [7:0]  w_drop_nxt;
  logic        w_in_ready;
  logic        w_drop;
  logic        w_out_free;

  assign w_out_free = !r_valid || bus.frame_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_count_nxt = r_count;
    w_data_nxt  = r_data;
    // A transferred word leaves the register unless something reloads it below.
    w_valid_nxt = r_valid && !bus.frame_ready;
    w_last_nxt  = r_last && !bus.frame_ready;
    w_drop_nxt  = r_drop;
    w_in_ready  = 1'b0;
    w_drop      = 1'b0;
`ifdef FRAMER_CKSUM_EN
    w_sum_nxt   = r_sum;
`endif

    case (r_state)
      IDLE: begin
        w_in_ready = (bus.mode == 2'd0);
        if (bus.in_valid && bus.mode == 2'd0) begin
          w_drop = 1'b1;
        end else if (bus.in_valid && w_out_free) begin
          // Header only; the tagged word stays on the input and becomes payload word 0.
          w_data_nxt  = {8'hA5, 6'b0, bus.mode};
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_ch_nxt    = bus.mode;
          w_count_nxt = 6'd0;
`ifdef FRAMER_CKSUM_EN
          w_sum_nxt   = 16'd0;
`endif
          w_state_nxt = PAYLOAD;
        end
      end

      PAYLOAD: begin
        w_in_ready = w_out_free;
        if (bus.in_valid && w_out_free) begin
          if (bus.mode == r_ch) begin
            w_data_nxt  = bus.multiplexed_data;
            w_valid_nxt = 1'b1;
            w_last_nxt  = 1'b0;
            w_count_nxt = r_count + 6'd1;
`ifdef FRAMER_CKSUM_EN
            w_sum_nxt   = r_sum + bus.multiplexed_data;
            if (r_count == LAST_IDX) w_state_nxt = CKSUM;
`else
            if (r_count == LAST_IDX) begin
              w_last_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end
`endif
          end else begin
            w_drop = 1'b1;
          end
        end
      end

`ifdef FRAMER_CKSUM_EN
      CKSUM: begin
        if (w_out_free) begin
          w_data_nxt  = r_sum;
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
`endif

      default: w_state_nxt = IDLE;
    endcase

    if (w_drop && r_drop != 8'hFF) w_drop_nxt = r_drop + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ch    <= 2'd0;
      r_count <= 6'd0;
      r_data  <= 16'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_drop  <= 8'd0;
`ifdef FRAMER_CKSUM_EN
      r_sum   <= 16'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_count <= w_count_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_drop  <= w_drop_nxt;
`ifdef FRAMER_CKSUM_EN
      r_sum   <= w_sum_nxt;
`endif
    end
  end

  assign bus.in_ready    = w_in_ready && !rst;
  assign bus.frame_data  = r_data;
  assign bus.frame_valid = r_valid;
  assign bus.frame_last  = r_last;
  assign bus.drop_count  = r_drop;

endmodule

// File: tb/tb_stream_framer.sv
// Directed plus randomized bench for stream_framer; a frame-level reference model
// predicts every output word and the drop counter from the accepted input words.
module tb_stream_framer;
  localparam int PAYLOAD_LEN = 4;
`ifdef FRAMER_CKSUM_EN
  localparam int FW = PAYLOAD_LEN + 2;
`else
  localparam int FW = PAYLOAD_LEN + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_framer_if bus ();
  stream_framer #(.PAYLOAD_LEN(PAYLOAD_LEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          cyc;
  } ow_t;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  ow_t exp_q[$];
  ow_t out_log[$];
  bit  rand_ready = 0;

  bit          m_in_frame = 0;
  logic [1:0]  m_ch = 2'd0;
  int          m_cnt = 0;
  int          m_sum = 0;
  int          m_drops = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_drop();
    if (m_drops < 255) m_drops++;
  endtask

  task automatic model_payload(input logic [15:0] d);
    m_sum = (m_sum + int'(d)) % 65536;
    m_cnt++;
    if (m_cnt == PAYLOAD_LEN) begin
`ifdef FRAMER_CKSUM_EN
      exp_q.push_back('{d, 1'b0, 0});
      exp_q.push_back('{16'(m_sum), 1'b1, 0});
`else
      exp_q.push_back('{d, 1'b1, 0});
`endif
      m_in_frame = 0;
    end else begin
      exp_q.push_back('{d, 1'b0, 0});
    end
  endtask

  // Frame rules applied to the stream of accepted words.
  task automatic model_accept(input logic [1:0] md, input logic [15:0] d);
    if (!m_in_frame) begin
      if (md == 2'd0) model_drop();
      else begin
        m_in_frame = 1;
        m_ch  = md;
        m_cnt = 0;
        m_sum = 0;
        exp_q.push_back('{{8'hA5, 6'b0, md}, 1'b0, 0});
        model_payload(d);
      end
    end else if (md == m_ch) model_payload(d);
    else model_drop();
  endtask

  always @(posedge clk) begin
    bit          was_rst;
    bit          hold_chk;
    logic [15:0] hold_d;
    logic        hold_l;
    ow_t         e;
    cyc++;
    was_rst  = (rst === 1'b1);
    hold_chk = 0;
    hold_d   = 16'd0;
    hold_l   = 1'b0;
    if (was_rst) begin
      chk("in_ready_during_rst", 32'(bus.in_ready), 32'd0);
      exp_q.delete();
      m_in_frame = 0;
      m_drops = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) model_accept(bus.mode, bus.multiplexed_data);
      if (bus.frame_valid && bus.frame_ready) begin
        out_log.push_back('{bus.frame_data, bus.frame_last, cyc});
        chk("out_word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", 32'(bus.frame_data), 32'(e.data));
          chk("out_last", 32'(bus.frame_last), 32'(e.last));
        end
      end
      if (bus.frame_valid && !bus.frame_ready) begin
        hold_chk = 1;
        hold_d   = bus.frame_data;
        hold_l   = bus.frame_last;
      end
    end
    #1;
    chk("drop_count", 32'(bus.drop_count), 32'(m_drops));
    if (was_rst) begin
      chk("rst_valid", 32'(bus.frame_valid), 32'd0);
      chk("rst_last", 32'(bus.frame_last), 32'd0);
      chk("rst_data", 32'(bus.frame_data), 32'd0);
    end
    if (hold_chk) begin
      chk("hold_valid", 32'(bus.frame_valid), 32'd1);
      chk("hold_data", 32'(bus.frame_data), 32'(hold_d));
      chk("hold_last", 32'(bus.frame_last), 32'(hold_l));
    end
  end

  always @(negedge clk) begin
    if (rand_ready) bus.frame_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic present(input logic [1:0] md, input logic [15:0] d);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mode = md;
    bus.multiplexed_data = d;
  endtask

  task automatic wait_accept();
    bit got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(posedge clk);
      got = bus.in_ready;
    end
    chk("accept_in_time", 32'(got), 32'd1);
  endtask

  task automatic send(input logic [1:0] md, input logic [15:0] d);
    present(md, d);
    wait_accept();
  endtask

  task automatic drain();
    bit done = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mode = 2'd0;
    bus.multiplexed_data = 16'd0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !bus.frame_valid;
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  task automatic check_basic_frame(input string tag);
    logic [15:0] exp030 [6];
    exp030 = '{16'hA501, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A};
    chk({tag, "_len"}, 32'(out_log.size()), 32'(FW));
    for (int k = 0; k < FW && k < out_log.size(); k++) begin
      chk({tag, "_data"}, 32'(out_log[k].data), 32'(exp030[k]));
      chk({tag, "_last"}, 32'(out_log[k].last), 32'(k == FW - 1));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.mode = 2'd0;
    bus.multiplexed_data = 16'd0;
    bus.frame_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(bus.frame_valid), 32'd0);
    chk("reset_data", 32'(bus.frame_data), 32'd0);
    chk("reset_drop", 32'(bus.drop_count), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;

    // Basic frame at full rate, checked against literal values and for back-to-back output.
    out_log.delete();
    for (int i = 1; i <= 4; i++) send(2'd1, 16'(i));
    drain();
    check_basic_frame("basic");
    for (int k = 1; k < out_log.size(); k++)
      chk("basic_rate", 32'(out_log[k].cyc - out_log[0].cyc), 32'(k));

    // Same frame with three cycles of backpressure while 0x0002 is on the output.
    out_log.delete();
    send(2'd1, 16'h0001);
    send(2'd1, 16'h0002);
    @(negedge clk);
    bus.frame_ready = 1'b0;
    bus.multiplexed_data = 16'h0003;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_data", 32'(bus.frame_data), 32'h0002);
    end
    @(negedge clk);
    bus.frame_ready = 1'b1;
    wait_accept();
    send(2'd1, 16'h0004);
    drain();
    check_basic_frame("bp");

    // Untagged words in IDLE are swallowed and counted.
    out_log.delete();
    for (int i = 0; i < 5; i++) send(2'd0, 16'($urandom));
    drain();
    chk("idle_drop_no_output", 32'(out_log.size()), 32'd0);
    chk("idle_drop_count", 32'(bus.drop_count), 32'd5);

    // Foreign-channel word in mid-frame.
    out_log.delete();
    send(2'd2, 16'h0B01);
    send(2'd2, 16'h0B02);
    send(2'd3, 16'h1234);
    send(2'd2, 16'h0B03);
    send(2'd2, 16'h0B04);
    drain();
    chk("foreign_drop_count", 32'(bus.drop_count), 32'd6);
    chk("foreign_len", 32'(out_log.size()), 32'(FW));
    if (out_log.size() >= 5) begin
      chk("foreign_header", 32'(out_log[0].data), 32'hA502);
      for (int k = 1; k <= 4; k++)
        chk("foreign_payload", 32'(out_log[k].data), 32'(16'h0B00 + 16'(k)));
`ifdef FRAMER_CKSUM_EN
      if (out_log.size() >= 6) chk("foreign_cksum", 32'(out_log[5].data), 32'h2C0A);
`endif
    end

    // Checksum wraps modulo 2^16.
    out_log.delete();
    for (int i = 0; i < 4; i++) send(2'd1, 16'hFFFF);
    drain();
    chk("wrap_len", 32'(out_log.size()), 32'(FW));
`ifdef FRAMER_CKSUM_EN
    if (out_log.size() >= 6) chk("wrap_cksum", 32'(out_log[5].data), 32'hFFFC);
`else
    if (out_log.size() >= 5) chk("wrap_last", 32'(out_log[4].last), 32'd1);
`endif

    // Reset in the middle of a frame abandons it.
    send(2'd1, 16'h0011);
    send(2'd1, 16'h0022);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(bus.frame_valid), 32'd0);
    chk("midrst_drop", 32'(bus.drop_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_log.delete();
    for (int i = 0; i < 4; i++) send(2'd3, 16'(16'h0031 + i));
    drain();
    chk("postrst_len", 32'(out_log.size()), 32'(FW));
    if (out_log.size() > 0) chk("postrst_header", 32'(out_log[0].data), 32'hA503);

    // Random traffic with random downstream stalls; the model checks every word.
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 7);
      send((r == 0) ? 2'd0 : 2'($urandom_range(1, 3)), 16'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
    end
    rand_ready = 0;
    @(negedge clk);
    bus.frame_ready = 1'b1;
    drain();

    // Drop counter saturates.
    for (int i = 0; i < 260; i++) send(2'd0, 16'(i));
    drain();
    chk("drop_saturated", 32'(bus.drop_count), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
